// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module : pll_lock_supervisor
// Brief  : PLL reset sequencer / lock qualifier that holds video logic in reset
//          until the PLL lock flag has been stable; counts retries and losses.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
   parameter int SYNC_STAGES    = 2,
   parameter int PLL_RST_CYCLES = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT   = 500000,
   parameter int CNT_W          = 8
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             locked_in,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic [3:0]       retry_cnt,
   output logic [1:0]       state_o
);

   typedef enum logic [1:0] {
      S_PLLRST = 2'd0,
      S_WAIT   = 2'd1,
      S_STABLE = 2'd2,
      S_RUN    = 2'd3
   } state_t;

   // One shared phase counter, sized for the longest phase.
   localparam int C_MAX01 = (PLL_RST_CYCLES > STABLE_CYCLES) ? PLL_RST_CYCLES : STABLE_CYCLES;
   localparam int C_MAX   = (C_MAX01 > LOCK_TIMEOUT) ? C_MAX01 : LOCK_TIMEOUT;
   localparam int C_CW    = (C_MAX < 2) ? 1 : $clog2(C_MAX + 1);

   localparam logic [C_CW-1:0] C_RST_LAST = C_CW'(PLL_RST_CYCLES - 1);
   localparam logic [C_CW-1:0] C_TO_LAST  = C_CW'(LOCK_TIMEOUT - 1);
   localparam logic [C_CW-1:0] C_STB_LAST = C_CW'(STABLE_CYCLES - 1);
   localparam logic [C_CW-1:0] C_ONE      = C_CW'(1);

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic [C_CW-1:0]        r_cnt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_pll_rst;
   logic                   r_sys_rst;
   logic                   r_ready;
   logic [CNT_W-1:0]       r_loss;
   logic [3:0]             r_retry;

   logic w_locked_s;
   logic w_cnt_clr;
   logic w_retry_inc;
   logic w_loss_inc;

   assign w_locked_s = r_sync[SYNC_STAGES-1];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_clr   = 1'b0;
      w_retry_inc = 1'b0;
      w_loss_inc  = 1'b0;
      case (r_state)
         S_PLLRST: begin
            if (r_cnt == C_RST_LAST) begin
               w_state_nxt = S_WAIT;
               w_cnt_clr   = 1'b1;
            end
         end
         S_WAIT: begin
            // Lock seen on the timeout cycle still counts as lock.
            if (w_locked_s) begin
               w_state_nxt = S_STABLE;
               w_cnt_clr   = 1'b1;
            end else if (r_cnt == C_TO_LAST) begin
               w_state_nxt = S_PLLRST;
               w_cnt_clr   = 1'b1;
               w_retry_inc = 1'b1;
            end
         end
         S_STABLE: begin
            if (!w_locked_s) begin
               w_state_nxt = S_WAIT;
               w_cnt_clr   = 1'b1;
            end else if (r_cnt == C_STB_LAST) begin
               w_state_nxt = S_RUN;
               w_cnt_clr   = 1'b1;
            end
         end
         S_RUN: begin
            w_cnt_clr = 1'b1;
            if (!w_locked_s) begin
               w_state_nxt = S_WAIT;
               w_loss_inc  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_PLLRST;
            w_cnt_clr   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state   <= S_PLLRST;
         r_cnt     <= '0;
         r_sync    <= '0;
         r_pll_rst <= 1'b1;
         r_sys_rst <= 1'b1;
         r_ready   <= 1'b0;
         r_loss    <= '0;
         r_retry   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_sync    <= {r_sync[SYNC_STAGES-2:0], locked_in};
         r_cnt     <= w_cnt_clr ? '0 : (r_cnt + C_ONE);
         // Outputs are decoded from the next state so they change on the transition edge.
         r_pll_rst <= (w_state_nxt == S_PLLRST);
         r_sys_rst <= (w_state_nxt != S_RUN);
         r_ready   <= (w_state_nxt == S_RUN);
         if (w_retry_inc && (r_retry != 4'hF)) begin
            r_retry <= r_retry + 4'd1;
         end
         if (w_loss_inc && (r_loss != {CNT_W{1'b1}})) begin
            r_loss <= r_loss + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign pll_rst       = r_pll_rst;
   assign sys_rst       = r_sys_rst;
   assign ready         = r_ready;
   assign lock_loss_cnt = r_loss;
   assign retry_cnt     = r_retry;
   assign state_o       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// Module : tb_pll_lock_supervisor
// Brief  : Directed self-checking bench for pll_lock_supervisor.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       locked_in = 1'b0;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic [7:0] lock_loss_cnt;
   logic [3:0] retry_cnt;
   logic [1:0] state_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pll_lock_supervisor #(
      .SYNC_STAGES   (2),
      .PLL_RST_CYCLES(4),
      .STABLE_CYCLES (8),
      .LOCK_TIMEOUT  (32),
      .CNT_W         (8)
   ) dut (
      .refclk       (clk),
      .rst          (rst),
      .locked_in    (locked_in),
      .pll_rst      (pll_rst),
      .sys_rst      (sys_rst),
      .ready        (ready),
      .lock_loss_cnt(lock_loss_cnt),
      .retry_cnt    (retry_cnt),
      .state_o      (state_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      locked_in = 1'b0;
      tick(); tick(); tick();
      total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_o); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL rst_pll_rst got=%0b exp=1", pll_rst); end
      total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL rst_sys_rst got=%0b exp=1", sys_rst); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%0b exp=0", ready); end
      total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL rst_loss got=%0d exp=0", lock_loss_cnt); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL rst_retry got=%0d exp=0", retry_cnt); end
      rst = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL pllrst_hold cyc=%0d got=%0b exp=1", i, pll_rst); end
      end
      tick();
      total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL pllrst_end got=%0b exp=0", pll_rst); end
      total++; if (state_o !== 2'd1) begin bad++; $display("FAIL pllrst_to_wait got=%0d exp=1", state_o); end
   endtask

   task automatic test_retry();
      int n;
      int m;
      for (int p = 1; p <= 17; p++) begin
         n = 0;
         while (pll_rst !== 1'b1 && n < 50) begin tick(); n++; end
         total++; if (n != 32) begin bad++; $display("FAIL retry_wait_len p=%0d got=%0d exp=32", p, n); end
         total++; if (retry_cnt !== ((p < 15) ? p[3:0] : 4'd15)) begin
            bad++; $display("FAIL retry_cnt p=%0d got=%0d exp=%0d", p, retry_cnt, (p < 15) ? p : 15);
         end
         m = 0;
         while (pll_rst !== 1'b0 && m < 20) begin tick(); m++; end
         total++; if (m != 4) begin bad++; $display("FAIL retry_pulse_len p=%0d got=%0d exp=4", p, m); end
      end
   endtask

   task automatic test_lock();
      locked_in = 1'b1;
      tick();  // E
      tick();  // E+1
      total++; if (state_o !== 2'd1) begin bad++; $display("FAIL lock_e1_state got=%0d exp=1", state_o); end
      tick();  // E+2
      total++; if (state_o !== 2'd2) begin bad++; $display("FAIL lock_e2_state got=%0d exp=2", state_o); end
      for (int i = 0; i < 7; i++) tick();  // E+9
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL lock_e9_ready got=%0b exp=0", ready); end
      tick();  // E+10
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL lock_e10_ready got=%0b exp=1", ready); end
      total++; if (sys_rst !== 1'b0) begin bad++; $display("FAIL lock_e10_sysrst got=%0b exp=0", sys_rst); end
      total++; if (state_o !== 2'd3) begin bad++; $display("FAIL lock_e10_state got=%0d exp=3", state_o); end
   endtask

   task automatic test_glitch();
      rst = 1'b1;
      locked_in = 1'b0;
      tick(); tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      total++; if (state_o !== 2'd1) begin bad++; $display("FAIL glitch_pre_wait got=%0d exp=1", state_o); end
      locked_in = 1'b1;
      tick(); tick(); tick();  // E+2
      total++; if (state_o !== 2'd2) begin bad++; $display("FAIL glitch_stable got=%0d exp=2", state_o); end
      tick(); tick(); tick();  // E+5
      locked_in = 1'b0;
      tick();                  // E+6 captures the low
      locked_in = 1'b1;
      tick();                  // E+7
      total++; if (state_o !== 2'd2) begin bad++; $display("FAIL glitch_e7 got=%0d exp=2", state_o); end
      tick();                  // E+8
      total++; if (state_o !== 2'd1) begin bad++; $display("FAIL glitch_back_wait got=%0d exp=1", state_o); end
      tick();                  // E+9
      total++; if (state_o !== 2'd2) begin bad++; $display("FAIL glitch_restable got=%0d exp=2", state_o); end
      for (int i = 0; i < 7; i++) tick();  // E+16
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL glitch_early_ready got=%0b exp=0", ready); end
      tick();                  // E+17
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL glitch_ready got=%0b exp=1", ready); end
   endtask

   task automatic test_run_drops();
      int  n;
      bit  saw_prst;
      saw_prst = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         locked_in = 1'b0;
         tick();  // F
         tick();  // F+1
         if (k <= 3) begin
            total++; if (ready !== 1'b1) begin bad++; $display("FAIL drop_f1_ready k=%0d got=%0b exp=1", k, ready); end
         end
         tick();  // F+2
         if (pll_rst !== 1'b0) saw_prst = 1'b1;
         if (k <= 3) begin
            total++; if (ready !== 1'b0) begin bad++; $display("FAIL drop_f2_ready k=%0d got=%0b exp=0", k, ready); end
            total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL drop_f2_sysrst k=%0d got=%0b exp=1", k, sys_rst); end
            total++; if (state_o !== 2'd1) begin bad++; $display("FAIL drop_f2_state k=%0d got=%0d exp=1", k, state_o); end
            total++; if (lock_loss_cnt !== k[7:0]) begin bad++; $display("FAIL drop_loss k=%0d got=%0d exp=%0d", k, lock_loss_cnt, k); end
         end
         if (k >= 255) begin
            total++; if (lock_loss_cnt !== 8'd255) begin bad++; $display("FAIL loss_sat k=%0d got=%0d exp=255", k, lock_loss_cnt); end
         end
         locked_in = 1'b1;
         n = 0;
         while (ready !== 1'b1 && n < 40) begin
            tick(); n++;
            if (pll_rst !== 1'b0) saw_prst = 1'b1;
         end
         total++; if (n != 11) begin bad++; $display("FAIL relock_latency k=%0d got=%0d exp=11", k, n); end
      end
      total++; if (saw_prst !== 1'b0) begin bad++; $display("FAIL drop_pll_rst got=%0b exp=0", saw_prst); end
   endtask

   task automatic test_rst_in_run();
      total++; if (state_o !== 2'd3) begin bad++; $display("FAIL rir_pre_state got=%0d exp=3", state_o); end
      rst = 1'b1;
      tick();
      total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rir_state got=%0d exp=0", state_o); end
      total++; if (pll_rst !== 1'b1) begin bad++; $display("FAIL rir_pll_rst got=%0b exp=1", pll_rst); end
      total++; if (sys_rst !== 1'b1) begin bad++; $display("FAIL rir_sys_rst got=%0b exp=1", sys_rst); end
      total++; if (ready !== 1'b0) begin bad++; $display("FAIL rir_ready got=%0b exp=0", ready); end
      total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL rir_loss got=%0d exp=0", lock_loss_cnt); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL rir_retry got=%0d exp=0", retry_cnt); end
   endtask

   task automatic test_timeout_tie();
      rst = 1'b1;
      locked_in = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 33; i++) tick();  // edge 33 after release
      locked_in = 1'b1;
      tick();  // 34: captured
      tick();  // 35: timer at last count
      total++; if (state_o !== 2'd1) begin bad++; $display("FAIL tie_wait got=%0d exp=1", state_o); end
      tick();  // 36: lock and timeout coincide
      total++; if (state_o !== 2'd2) begin bad++; $display("FAIL tie_state got=%0d exp=2", state_o); end
      total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL tie_retry got=%0d exp=0", retry_cnt); end
      total++; if (pll_rst !== 1'b0) begin bad++; $display("FAIL tie_pll_rst got=%0b exp=0", pll_rst); end
   endtask

   initial begin
      test_reset();
      test_retry();
      test_lock();
      test_glitch();
      test_run_drops();
      test_rst_in_run();
      test_timeout_tie();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
